// File: rtl/ccff_loader.sv
// ccff_loader: drives a ccff_head -> ccff_tail configuration chain from a valid/ready word stream.
// Optional CCFF_READBACK_EN adds a mirror register and a non-destructive VERIFY pass.
module ccff_loader #(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned DATA_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int unsigned NWORDS    = (CHAIN_LEN + DATA_W - 1) / DATA_W;
    localparam int unsigned LAST_BITS = CHAIN_LEN - (NWORDS - 1) * DATA_W;
    localparam int unsigned REM_W     = $clog2(DATA_W + 1);
    localparam int unsigned WCNT_W    = $clog2(NWORDS + 1);
    localparam int unsigned EM_W      = $clog2(2 * CHAIN_LEN + 1);

`ifdef CCFF_READBACK_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [EM_W-1:0]     em_q, em_d;
    logic                head_q, head_d;
    logic                shift_q, shift_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                ready_c;
    logic                emit;
    logic                emit_bit;
    logic [REM_W-1:0]    nbits;

`ifdef CCFF_READBACK_EN
    logic [CHAIN_LEN-1:0] mirror_q, mirror_d;
    logic                 vshift_q, vshift_d;
`else
    logic                 unused_tail;
    assign unused_tail = ccff_tail;
`endif

    // State and datapath registers
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q  <= S_IDLE;
            buf_q    <= '0;
            rem_q    <= '0;
            wcnt_q   <= '0;
            em_q     <= '0;
            head_q   <= 1'b0;
            shift_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef CCFF_READBACK_EN
            mirror_q <= '0;
            vshift_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            rem_q    <= rem_d;
            wcnt_q   <= wcnt_d;
            em_q     <= em_d;
            head_q   <= head_d;
            shift_q  <= shift_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
`ifdef CCFF_READBACK_EN
            mirror_q <= mirror_d;
            vshift_q <= vshift_d;
`endif
        end
    end

    // Next-state, buffer drain and emission of the next chain bit
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        rem_d    = rem_q;
        wcnt_d   = wcnt_q;
        em_d     = em_q;
        head_d   = head_q;
        shift_d  = 1'b0;
        error_d  = error_q;
        ready_c  = 1'b0;
        emit     = 1'b0;
        emit_bit = 1'b0;
        nbits    = (wcnt_q == WCNT_W'(NWORDS - 1)) ? REM_W'(LAST_BITS) : REM_W'(DATA_W);
`ifdef CCFF_READBACK_EN
        mirror_d = mirror_q;
        vshift_d = 1'b0;
        if (vshift_q && (ccff_tail != head_q)) error_d = 1'b1;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    buf_d   = '0;
                    rem_d   = '0;
                    wcnt_d  = '0;
                    em_d    = '0;
                    error_d = 1'b0;
                end
            end
            S_LOAD: begin
                // Accept when empty or while the last buffered bit goes out
                ready_c = (wcnt_q != WCNT_W'(NWORDS)) && (rem_q <= REM_W'(1));
                if (rem_q != '0) begin
                    emit     = 1'b1;
                    emit_bit = buf_q[0];
                    buf_d    = buf_q >> 1;
                    rem_d    = rem_q - REM_W'(1);
                end
                if (ready_c && cfg_valid) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (rem_q == '0) begin
                        emit     = 1'b1;
                        emit_bit = cfg_data[0];
                        buf_d    = cfg_data >> 1;
                        rem_d    = nbits - REM_W'(1);
                    end else begin
                        buf_d = cfg_data;
                        rem_d = nbits;
                    end
                end
                if (em_q == EM_W'(CHAIN_LEN)) begin
`ifdef CCFF_READBACK_EN
                    state_d  = S_VERIFY;
                    emit     = 1'b1;
                    emit_bit = mirror_q[0];
                    vshift_d = 1'b1;
`else
                    state_d  = S_DONE;
`endif
                end
            end
`ifdef CCFF_READBACK_EN
            S_VERIFY: begin
                // Recirculate the mirror so the chain ends up unchanged
                if (em_q == EM_W'(2 * CHAIN_LEN)) begin
                    state_d = S_DONE;
                end else begin
                    emit     = 1'b1;
                    emit_bit = mirror_q[0];
                    vshift_d = 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (emit) begin
            head_d  = emit_bit;
            shift_d = 1'b1;
            em_d    = em_q + EM_W'(1);
`ifdef CCFF_READBACK_EN
            mirror_d = (mirror_q >> 1) | (CHAIN_LEN'(emit_bit) << (CHAIN_LEN - 1));
`endif
        end

        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    assign cfg_ready     = ready_c;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: randomized loads of ccff_loader into a behavioural chain model,
// checked by a bit/done scoreboard plus a small CHAIN_LEN=1, DATA_W=1 instance.
`timescale 1ns/1ps
module tb_ccff_loader;
    localparam int unsigned L  = 12;
    localparam int unsigned W  = 8;
    localparam int unsigned NW = (L + W - 1) / W;
`ifdef CCFF_READBACK_EN
    localparam int unsigned VLEN = L;
    localparam bit          RB   = 1'b1;
`else
    localparam int unsigned VLEN = 0;
    localparam bit          RB   = 1'b0;
`endif

    typedef struct {
        logic [L-1:0] chain;
        logic         err;
        int unsigned  due;
    } done_t;

    logic         clk = 1'b0;
    logic         prog_reset, start, cfg_valid, cfg_ready;
    logic [W-1:0] cfg_data;
    logic         ccff_head, ccff_shift_en, ccff_tail, busy, done, error;
    logic [L-1:0] chain, chain_nx;
    bit           stuck;
    int           total, bad;
    int unsigned  cyc;

    logic         o_start, o_valid, o_ready, o_head, o_sh, o_busy, o_done, o_err;
    logic [0:0]   o_data;
    logic         o_chain;

    bit           exp_bits[$];
    done_t        exp_done[$];
    done_t        md;
    int unsigned  nshift;
    logic         prev_head;
    bit           skip, was_done, mon_en;
    logic [W-1:0] wv [NW];

    always #5 clk = ~clk;

    ccff_loader #(.CHAIN_LEN(L), .DATA_W(W)) u_dut (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .error(error)
    );

    ccff_loader #(.CHAIN_LEN(1), .DATA_W(1)) u_one (
        .prog_clk(clk), .prog_reset(prog_reset), .start(o_start),
        .cfg_valid(o_valid), .cfg_ready(o_ready), .cfg_data(o_data),
        .ccff_head(o_head), .ccff_shift_en(o_sh), .ccff_tail(o_chain),
        .busy(o_busy), .done(o_done), .error(o_err)
    );

    // Behavioural chain: index 0 nearest the head; optional flop 3 stuck at 0
    always_comb begin
        chain_nx = ccff_shift_en ? {chain[L-2:0], ccff_head} : chain;
        if (stuck) chain_nx[3] = 1'b0;
    end
    assign ccff_tail = chain[L-1];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        chain <= chain_nx;
        if (o_sh) o_chain <= o_head;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected bits on every shift, expected results on every done
    always @(negedge clk) begin
        if (mon_en) begin
            if (!busy) check("ready_idle", 64'(cfg_ready), 64'd0);
            if (was_done) begin
                check("done_pulse", 64'(done), 64'd0);
                check("busy_after_done", 64'(busy), 64'd0);
            end
            if (ccff_shift_en) begin
                nshift++;
                if (exp_bits.size() == 0) check("extra_shift", 64'd1, 64'd0);
                else check("head_bit", 64'(ccff_head), 64'(exp_bits.pop_front()));
            end else if (!skip) begin
                check("head_hold", 64'(ccff_head), 64'(prev_head));
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    md = exp_done.pop_front();
                    check("shift_count", 64'(nshift), 64'(L + VLEN));
                    check("chain", 64'(chain), 64'(md.chain));
                    check("error", 64'(error), 64'(md.err));
                    if (md.due != 0) check("done_cycle", 64'(cyc), 64'(md.due));
                end
                nshift = 0;
            end
            if (prog_reset) nshift = 0;
        end
        was_done  = done;
        prev_head = ccff_head;
        skip      = prog_reset;
    end

    task automatic push_expect(input bit with_stuck, input int unsigned due);
        bit    b[$];
        done_t d;
        for (int i = 0; i < L; i++) b.push_back(wv[i / W][i % W]);
        for (int i = 0; i < L; i++) d.chain[L-1-i] = b[i];
        d.err = 1'b0;
        d.due = due;
        if (with_stuck) begin
            d.chain = d.chain & L'(7);
            foreach (b[i]) if (b[i]) d.err = 1'b1;
        end
        foreach (b[i]) exp_bits.push_back(b[i]);
        if (RB) foreach (b[i]) exp_bits.push_back(b[i]);
        exp_done.push_back(d);
    endtask

    // Stream wv[] into the DUT; gap = idle source cycles between words
    task automatic do_load(input int gap, input bit poke, input bit with_stuck, input bit abort);
        bit          acc, fin;
        int unsigned c0;
        cfg_valid = 1'(($urandom_range(0, 1)));
        cfg_data  = W'($urandom);
        @(posedge clk); #1;
        start = 1'b1;
        c0 = cyc;
        if (!abort) push_expect(with_stuck, (gap == 0) ? c0 + L + VLEN + 2 : 0);
        else for (int i = 0; i < L; i++) exp_bits.push_back(wv[i / W][i % W]);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < NW; k++) begin
            if (k > 0) repeat (gap) begin
                cfg_valid = 1'b0;
                @(posedge clk); #1;
            end
            cfg_valid = 1'b1;
            cfg_data  = wv[k];
            if (k == 1) start = poke;
            acc = 1'b0;
            for (int t = 0; t < 64 && !acc; t++) begin
                @(negedge clk);
                acc = cfg_ready;
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (!acc) check("accept_timeout", 64'd0, 64'd1);
            if (abort) break;
        end
        cfg_data = W'($urandom);
        if (abort) begin
            // Word 0 went out at cycle 1; shifts run cycles 2.., reset lands after 5
            repeat (4) @(posedge clk);
            #1;
            prog_reset = 1'b1;
            cfg_valid  = 1'b0;
            @(posedge clk); #1;
            prog_reset = 1'b0;
            exp_bits.delete();
            exp_done.delete();
            @(negedge clk);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_shift", 64'(ccff_shift_en), 64'd0);
            check("rst_head", 64'(ccff_head), 64'd0);
            check("rst_ready", 64'(cfg_ready), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_error", 64'(error), 64'd0);
            return;
        end
        @(negedge clk);
        check("ready_after_last", 64'(cfg_ready), 64'd0);
        fin = 1'b0;
        for (int t = 0; t < 200 && !fin; t++) begin
            @(negedge clk);
            fin = !busy;
        end
        if (!fin) check("done_timeout", 64'd0, 64'd1);
        cfg_valid = 1'b0;
    endtask

    // Single-flop chain with a one-bit word
    task automatic one_load(input logic b);
        @(posedge clk); #1;
        o_start = 1'b1;
        @(posedge clk); #1;
        o_start = 1'b0;
        o_valid = 1'b1;
        o_data  = b;
        @(negedge clk);
        check("one_ready", 64'(o_ready), 64'd1);
        @(posedge clk); #1;
        o_valid = 1'b0;
        @(negedge clk);
        check("one_shift", 64'(o_sh), 64'd1);
        check("one_head", 64'(o_head), 64'(b));
        repeat (VLEN + 1) @(negedge clk);
        check("one_done", 64'(o_done), 64'd1);
        check("one_chain", 64'(o_chain), 64'(b));
        check("one_error", 64'(o_err), 64'd0);
        @(negedge clk);
        check("one_idle", 64'(o_busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; cyc = 0; nshift = 0;
        stuck = 1'b0; mon_en = 1'b0; skip = 1'b1; was_done = 1'b0;
        chain = '0; o_chain = 1'b0;
        prog_reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        o_start = 1'b0; o_valid = 1'b0; o_data = '0;
        repeat (3) @(posedge clk);
        #1;
        prog_reset = 1'b0;
        @(negedge clk);
        check("reset_ready", 64'(cfg_ready), 64'd0);
        check("reset_head", 64'(ccff_head), 64'd0);
        check("reset_shift", 64'(ccff_shift_en), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_error", 64'(error), 64'd0);
        mon_en = 1'b1;

        wv[0] = 8'hFF; wv[1] = 8'h3C; do_load(0, 1'b0, 1'b0, 1'b0);
        wv[0] = 8'hA5; wv[1] = 8'h00; do_load(0, 1'b0, 1'b0, 1'b0);
        wv[0] = 8'hA5; wv[1] = 8'h0A; do_load(10, 1'b0, 1'b0, 1'b0);
        wv[0] = 8'h5A; wv[1] = 8'h06; do_load(3, 1'b0, 1'b0, 1'b0);
        wv[0] = 8'h96; wv[1] = 8'h09; do_load(0, 1'b1, 1'b0, 1'b0);
        wv[0] = 8'hC3; wv[1] = 8'h07; do_load(0, 1'b0, 1'b0, 1'b1);
        wv[0] = 8'h71; wv[1] = 8'h0E; do_load(0, 1'b0, 1'b0, 1'b0);
        if (RB) begin
            stuck = 1'b1;
            wv[0] = 8'hA5; wv[1] = 8'h0F; do_load(0, 1'b0, 1'b1, 1'b0);
            stuck = 1'b0;
            wv[0] = 8'hA5; wv[1] = 8'h05; do_load(0, 1'b0, 1'b0, 1'b0);
        end
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < NW; k++) wv[k] = W'($urandom);
            do_load(($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 10)),
                    1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        one_load(1'b1);
        one_load(1'b0);
        one_load(1'b1);

        repeat (3) @(negedge clk);
        check("leftover", 64'(exp_bits.size() + exp_done.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
